// File: rtl/dat_mem_dp.sv
// Dual-port data memory: port A read/write, port B read-only, registered reads
// with valid flags, write-first bypass, and an optional post-reset clear sweep.
module dat_mem_dp #(
  parameter int              DW             = 8,
  parameter int              AW             = 8,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0]   CLEAR_VAL      = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_wr_en,
  input  logic          a_rd_en,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_valid,
  input  logic          b_rd_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout,
  output logic          b_valid,
  output logic          ready,
  output logic          busy_err
);

  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW:0]   clr_cnt_reg, clr_cnt_next;
  logic          ready_reg, ready_next;
  logic          busy_err_reg, busy_err_next;
  logic          clr_we;
  logic          any_req;
  logic          wr_fire;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    rd_en;
  logic [AW-1:0] rd_addr [2];

  // State register and the status flags that follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_cnt_reg  <= '0;
      ready_reg    <= 1'b0;
      busy_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      ready_reg    <= ready_next;
      busy_err_reg <= busy_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    clr_we        = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          clr_we       = rst_n;
          clr_cnt_next = clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_IDX) begin
            state_next = ST_RUN;
          end
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_CLEAR;
    endcase
    ready_next    = (state_next == ST_RUN);
    any_req       = a_wr_en | a_rd_en | b_rd_en;
    busy_err_next = busy_err_reg | (~ready_reg & any_req);
  end

  // rst_n in the enable drops a store that coincides with reset assertion.
  assign wr_fire = ready_reg & a_wr_en & rst_n;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_reg[AW-1:0]] <= CLEAR_VAL;
    end else if (wr_fire) begin
      mem[a_addr] <= a_din;
    end
  end

  assign rd_en      = {b_rd_en, a_rd_en};
  assign rd_addr[0] = a_addr;
  assign rd_addr[1] = b_addr;

  // One registered read port per index; both bypass a same-address store on port A.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic          rd_fire;
      logic          bypass;
      logic [DW-1:0] dout_reg;
      logic          valid_reg;

      assign rd_fire = ready_reg & rd_en[gi];
      assign bypass  = wr_fire & (rd_addr[gi] == a_addr);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= rd_fire;
          if (rd_fire) begin
            dout_reg <= bypass ? a_din : mem[rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign a_dout   = g_rd[0].dout_reg;
  assign a_valid  = g_rd[0].valid_reg;
  assign b_dout   = g_rd[1].dout_reg;
  assign b_valid  = g_rd[1].valid_reg;
  assign ready    = ready_reg;
  assign busy_err = busy_err_reg;

endmodule

// File: tb/tb_dat_mem_dp.sv
// Directed bench for dat_mem_dp: a clearing instance and a retaining instance,
// with read results scoreboarded against queued expectations.
module tb_dat_mem_dp;

  logic       clk;
  logic       rst_n, rst_n2;

  logic       a_wr_en, a_rd_en, b_rd_en;
  logic [7:0] a_addr, a_din, b_addr;
  logic [7:0] a_dout, b_dout;
  logic       a_valid, b_valid, ready, busy_err;

  logic       n_wr_en, n_rd_en, n_b_rd_en;
  logic [7:0] n_addr, n_din, n_b_addr;
  logic [7:0] n_a_dout, n_b_dout;
  logic       n_a_valid, n_b_valid, n_ready, n_busy_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qn[$];

  dat_mem_dp #(.DW(8), .AW(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wr_en(a_wr_en), .a_rd_en(a_rd_en), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
    .ready(ready), .busy_err(busy_err)
  );

  dat_mem_dp #(.DW(8), .AW(8), .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(8'h00)) dut_nc (
    .clk(clk), .rst_n(rst_n2),
    .a_wr_en(n_wr_en), .a_rd_en(n_rd_en), .a_addr(n_addr), .a_din(n_din),
    .a_dout(n_a_dout), .a_valid(n_a_valid),
    .b_rd_en(n_b_rd_en), .b_addr(n_b_addr), .b_dout(n_b_dout), .b_valid(n_b_valid),
    .ready(n_ready), .busy_err(n_busy_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and drain the scoreboards: one queued entry means a
  // valid result is due now, an empty queue means valid must be low.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk1({e.tag, "_a_valid"}, a_valid, 1'b1);
      chk8({e.tag, "_a_dout"}, a_dout, e.data);
    end else begin
      chk1("a_valid_idle", a_valid, 1'b0);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk1({e.tag, "_b_valid"}, b_valid, 1'b1);
      chk8({e.tag, "_b_dout"}, b_dout, e.data);
    end else begin
      chk1("b_valid_idle", b_valid, 1'b0);
    end
    if (qn.size() > 0) begin
      e = qn.pop_front();
      chk1({e.tag, "_n_valid"}, n_a_valid, 1'b1);
      chk8({e.tag, "_n_dout"}, n_a_dout, e.data);
    end else begin
      chk1("n_valid_idle", n_a_valid, 1'b0);
    end
  endtask

  task automatic push(input int port, input string tag, input logic [7:0] data);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    case (port)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qn.push_back(e);
    endcase
  endtask

  task automatic idle();
    a_wr_en = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0;
    n_wr_en = 1'b0; n_rd_en = 1'b0; n_b_rd_en = 1'b0;
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [7:0] data);
    a_wr_en = 1'b1; a_addr = addr; a_din = data;
    $display("WR dut    addr=%02h data=%02h", addr, data);
    cyc();
    a_wr_en = 1'b0;
  endtask

  task automatic rd_a(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    a_rd_en = 1'b1; a_addr = addr;
    push(0, tag, exp);
    cyc();
    a_rd_en = 1'b0;
  endtask

  task automatic wr_n(input logic [7:0] addr, input logic [7:0] data);
    n_wr_en = 1'b1; n_addr = addr; n_din = data;
    $display("WR dut_nc addr=%02h data=%02h", addr, data);
    cyc();
    n_wr_en = 1'b0;
  endtask

  task automatic rd_n(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    n_rd_en = 1'b1; n_addr = addr;
    push(2, tag, exp);
    cyc();
    n_rd_en = 1'b0;
  endtask

  // Count a clear sweep edge by edge; optionally inject a request at edge
  // req_at, or pull reset at edge abort_at and stop early.
  task automatic sweep(input string tag, input int req_at, input int abort_at);
    for (int i = 1; i <= 256; i++) begin
      cyc();
      chk1({tag, "_ready"}, ready, (i == 256));
      if (req_at > 0 && i == req_at - 1) begin
        a_wr_en = 1'b1; a_addr = 8'h03; a_din = 8'hFF;
      end
      if (req_at > 0 && i == req_at) begin
        a_wr_en = 1'b0;
        chk1({tag, "_busy_err_set"}, busy_err, 1'b1);
      end
      if (abort_at > 0 && i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk1({tag, "_abort_ready"}, ready, 1'b0);
        chk1({tag, "_abort_a_valid"}, a_valid, 1'b0);
        chk1({tag, "_abort_b_valid"}, b_valid, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_n2 = 1'b0;
    idle();
    a_addr = '0; a_din = '0; b_addr = '0;
    n_addr = '0; n_din = '0; n_b_addr = '0;

    // Reset values
    cyc(); cyc();
    chk8("rst_a_dout", a_dout, 8'h00);
    chk8("rst_b_dout", b_dout, 8'h00);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_busy_err", busy_err, 1'b0);
    chk1("rst_n_ready", n_ready, 1'b0);

    // Retaining instance: ready one cycle after release, contents survive reset
    rst_n2 = 1'b1;
    cyc();
    chk1("nc_ready_rise", n_ready, 1'b1);
    wr_n(8'h04, 8'h77);
    wr_n(8'hC8, 8'h99);
    rd_n(8'h04, 8'h77, "nc_rd4");
    rd_n(8'hC8, 8'h99, "nc_rdc8");
    rst_n2 = 1'b0;
    #1;
    chk1("nc_rst_ready", n_ready, 1'b0);
    cyc(); cyc();
    rst_n2 = 1'b1;
    chk1("nc_ready_before_edge", n_ready, 1'b0);
    cyc();
    chk1("nc_ready_again", n_ready, 1'b1);
    rd_n(8'h04, 8'h77, "nc_keep4");
    rd_n(8'hC8, 8'h99, "nc_keepc8");
    chk1("nc_busy_err", n_busy_err, 1'b0);
    chk1("nc_b_valid", n_b_valid, 1'b0);

    // Clear sweep with a write attempted at edge 10
    rst_n = 1'b1;
    sweep("sweep1", 10, 0);
    chk1("busy_err_sticky", busy_err, 1'b1);
    rd_a(8'h03, 8'h00, "clr_addr3");

    // Basic write then read, valid for exactly one cycle
    wr_a(8'h10, 8'h3C);
    rd_a(8'h10, 8'h3C, "wr_rd_10");
    cyc();

    // Port A write-first when writing and reading together
    a_wr_en = 1'b1; a_rd_en = 1'b1; a_addr = 8'h30; a_din = 8'h6B;
    $display("WR dut    addr=%02h data=%02h", 8'h30, 8'h6B);
    push(0, "a_wr_first", 8'h6B);
    cyc();
    idle();
    rd_a(8'h30, 8'h6B, "a_wr_first_mem");

    // Collision: port B sees port A's write data
    a_wr_en = 1'b1; a_addr = 8'h20; a_din = 8'h5A;
    b_rd_en = 1'b1; b_addr = 8'h20;
    $display("WR dut    addr=%02h data=%02h", 8'h20, 8'h5A);
    push(1, "collide_b", 8'h5A);
    cyc();
    idle();
    rd_a(8'h20, 8'h5A, "collide_mem");

    // Independent dual reads
    wr_a(8'h01, 8'h11);
    wr_a(8'h02, 8'h22);
    a_rd_en = 1'b1; a_addr = 8'h01;
    b_rd_en = 1'b1; b_addr = 8'h02;
    push(0, "dual_a", 8'h11);
    push(1, "dual_b", 8'h22);
    cyc();
    idle();
    cyc();
    chk8("a_dout_hold", a_dout, 8'h11);
    chk1("busy_err_run", busy_err, 1'b1);

    // Preload word 5, then reset while both valids are high
    wr_a(8'h05, 8'hAA);
    a_rd_en = 1'b1; a_addr = 8'h05;
    b_rd_en = 1'b1; b_addr = 8'h10;
    push(0, "preload_a", 8'hAA);
    push(1, "preload_b", 8'h3C);
    cyc();
    idle();
    rst_n = 1'b0;
    #1;
    chk1("run_rst_a_valid", a_valid, 1'b0);
    chk1("run_rst_b_valid", b_valid, 1'b0);
    chk1("run_rst_ready", ready, 1'b0);
    chk1("run_rst_busy_err", busy_err, 1'b0);
    chk8("run_rst_a_dout", a_dout, 8'h00);
    cyc(); cyc();

    // Sweep aborted at edge 100, then a full restart
    rst_n = 1'b1;
    sweep("sweep2", 0, 100);
    cyc(); cyc();
    rst_n = 1'b1;
    sweep("sweep3", 0, 0);
    chk1("sweep3_busy_err", busy_err, 1'b0);
    rd_a(8'h05, 8'h00, "clr_preload5");
    rd_a(8'h20, 8'h00, "clr_addr20");
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dat_mem_dp.md
Name: dat_mem_dp

Overview:
Parametrised successor to the team's 8x256 data memory, used as the processor's data store. It provides:
- one read/write port (A) and one read-only port (B);
- registered reads with a valid flag;
- write-first bypass on address collisions;
- a post-reset clear sweep gated by a ready flag.

The core pipeline issues loads and stores on port A. Port B serves a debug or second-operand reader.

Parameters:
DW, 8, data width in bits
AW, 8, address width; depth = 2**AW words
CLEAR_ON_RESET, 1, 1 = zero every word after reset before ready; 0 = contents retained, ready one cycle after reset release
CLEAR_VAL, 0, DW-bit value written during the clear sweep

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
a_wr_en  input  1  port A write strobe
a_rd_en  input  1  port A read strobe
a_addr  input  AW  port A address
a_din  input  DW  port A write data
a_dout  output  DW  port A registered read data
a_valid  output  1  a_dout holds data for a read issued the previous cycle
b_rd_en  input  1  port B read strobe
b_addr  input  AW  port B address
b_dout  output  DW  port B registered read data
b_valid  output  1  b_dout holds data for a read issued the previous cycle
ready  output  1  memory accepts requests
busy_err  output  1  sticky: a request arrived while ready=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: a_dout=0, b_dout=0, a_valid=0, b_valid=0, ready=0, busy_err=0.
  - State machine to CLEAR; clear counter=0.
- States:
  - CLEAR: entered at reset release.
    - If CLEAR_ON_RESET=1: each cycle write CLEAR_VAL to word[counter] and increment the counter. After word 2**AW-1 is written, go to RUN.
    - If CLEAR_ON_RESET=0: go to RUN on the first clock after reset release, with no writes.
  - RUN: ready=1. RUN exits only on reset.
- Clear latency: ready rises 2**AW clock edges after reset release (256 for defaults). The counter is AW+1 bits so terminal detect does not wrap.
- Requests while ready=0 (any of a_wr_en, a_rd_en, b_rd_en high):
  - The request is ignored: no write, valid stays 0.
  - busy_err is set and stays set until reset.
- Port A write (RUN, a_wr_en=1): mem[a_addr] <= a_din at the rising edge.
- Port A read (RUN, a_rd_en=1):
  - a_dout <= mem[a_addr] at the edge; a_valid=1 for exactly the following cycle.
  - If a_rd_en=0, a_valid=0 and a_dout holds its last value.
- a_wr_en and a_rd_en both high: write-first. a_dout receives a_din and memory is updated.
- Port B read: same latency and valid rule as port A. Reads are independent of port A.
- Collision (b_rd_en=1, a_wr_en=1, b_addr==a_addr): write-first bypass. b_dout <= a_din.
- Reads never modify memory. Writes are full-word; no partial writes.
- Addresses are always in range (2**AW words); no wrap or bounds logic.
- Reset mid-sweep or mid-RUN:
  - Returns immediately to CLEAR; counter=0; valids drop in the same instant (asynchronous).
  - Writes in flight at the reset assertion edge are not performed.
- Simulation trace: writes print address and data. No display on reads.

Test Plan:
- Clear sweep: preload mem[5]=8'hAA; release reset with CLEAR_ON_RESET=1. Required: ready low for 256 cycles, then high. A port A read of addr 5 then returns 8'h00 with a_valid high one cycle after the request.
- Basic write/read latency: in RUN, write 8'h3C to addr 8'h10, then read it on the next cycle. Required: a_dout=8'h3C and a_valid=1 exactly one cycle after the read strobe, then a_valid=0.
- Same-cycle collision: a_wr_en=1, a_addr=8'h20, a_din=8'h5A, with b_rd_en=1, b_addr=8'h20. Required: next cycle b_dout=8'h5A, b_valid=1, and a later port A read of 8'h20 returns 8'h5A.
- Dual independent reads: mem[1]=8'h11, mem[2]=8'h22; read A@1 and B@2 in the same cycle. Required: a_dout=8'h11 and b_dout=8'h22 next cycle, both valid.
- Request during clear: assert a_wr_en at addr 3 with data 8'hFF at cycle 10 of the sweep. Required: busy_err=1 and sticky; after ready, mem[3]=8'h00.
- Mid-sweep reset plus CLEAR_ON_RESET=0 variant:
  - Pull rst_n low at cycle 100 of the sweep. Required: ready=0 and valids=0 immediately; the sweep restarts at 0 and takes a full 256 cycles.
  - With CLEAR_ON_RESET=0: ready=1 one cycle after reset release, and prior contents are retained.
